// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry adder: CHUNK bits per clock through a carry register, valid/ready on both sides.
// Optional macro RCA_SEQ_SUB_EN adds a sub input that computes a + ~b + cin.
module rca_seq_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH < 2 || CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("rca_seq_adder: WIDTH must be >= 2 and an exact multiple of CHUNK");
  end

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             accept;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   sl_res;
  logic             msb_cin;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath enables
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        step = 1'b1;
        if (idx == IW'(NSLICE - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Current slice add; carry into the MSB is recovered from the MSB sum bit
  assign base    = 32'(idx) * CHUNK;
  assign a_sl    = a_q[base +: CHUNK];
  assign b_sl    = b_q[base +: CHUNK];
  assign sl_res  = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK + 1)'(carry);
  assign msb_cin = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sl_res[CHUNK-1];

  // Handshake flags, operand latches and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept) begin
        a_q   <= a;
`ifdef RCA_SEQ_SUB_EN
        b_q   <= sub ? ~b : b;
`else
        b_q   <= b;
`endif
        carry <= cin;
        idx   <= '0;
      end
      if (step) begin
        sum[base +: CHUNK] <= sl_res[CHUNK-1:0];
        carry              <= sl_res[CHUNK];
        if (last) begin
          cout     <= sl_res[CHUNK];
          overflow <= msb_cin ^ sl_res[CHUNK];
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rca_seq_adder.sv
// Scoreboard bench for rca_seq_adder: directed 16/4 vectors plus (16,16), (32,8), (8,1) sweeps.
`timescale 1ns/1ps
module tb_rca_seq_adder;

  localparam int unsigned W  = 16;
  localparam int unsigned NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, srst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic         cin, sub, cout, overflow;
  logic [W-1:0] a, b, sum;

  int n_tests = 0;
  int n_fail  = 0;
  int sweep_done = 0;
  logic [W+1:0] exp_q[$];

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  rca_seq_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef RCA_SEQ_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  // Monitor: pop expected {overflow, cout, sum} on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_out: got sum %0h with empty scoreboard", sum);
      end else begin
        check("result", 64'({overflow, cout, sum}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic ts, input logic [W+1:0] e, input bit chk_lat);
    int lat;
    int t;
    bit busy_ok;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_before_accept", 64'(in_ready), 64'(1));
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_v; cin = ~tc;
    lat = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (chk_lat) begin
      check("latency", 64'(lat), 64'(NS));
      check("in_ready_low_while_busy", 64'({busy_ok, in_ready}), 64'(2'b10));
    end
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  // Parameter sweep instances with an arithmetic reference model
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned SW = (g == 0) ? 16 : (g == 1) ? 32 : 8;
    localparam int unsigned SC = (g == 0) ? 16 : (g == 1) ? 8 : 1;
    localparam int unsigned SN = SW / SC;

    logic          s_in_valid, s_in_ready, s_out_valid, s_cin, s_cout, s_ovf;
    logic [SW-1:0] s_a, s_b, s_sum;
    logic [SW+1:0] s_q[$];

    rca_seq_adder #(.WIDTH(SW), .CHUNK(SC)) dut_s (
      .clk(clk), .rst_n(srst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .cin(s_cin),
`ifdef RCA_SEQ_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(s_out_valid), .out_ready(1'b1),
      .sum(s_sum), .cout(s_cout), .overflow(s_ovf)
    );

    always @(negedge clk) begin
      if (srst_n && s_out_valid) begin
        if (s_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sweep%0d_spurious_out: got sum %0h with empty scoreboard", g, s_sum);
        end else begin
          check($sformatf("sweep%0d_result", g), 64'({s_ovf, s_cout, s_sum}), 64'(s_q.pop_front()));
        end
      end
    end

    initial begin
      logic [SW:0]   full;
      logic [SW-1:0] ra, rb;
      logic          rc, rov;
      int            lat;
      s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0;
      @(posedge srst_n);
      for (int i = 0; i < 200; i++) begin
        ra = SW'($urandom); rb = SW'($urandom); rc = 1'($urandom);
        if (i == 0) begin ra = '1; rb = '0; rc = 1'b1; end
        full = (SW + 1)'(ra) + (SW + 1)'(rb) + (SW + 1)'(rc);
        rov  = (ra[SW-1] == rb[SW-1]) && (full[SW-1] != ra[SW-1]);
        lat = 0;
        while (!s_in_ready && lat < 100) begin
          @(posedge clk); #1;
          lat++;
        end
        s_a = ra; s_b = rb; s_cin = rc; s_in_valid = 1'b1;
        s_q.push_back({rov, full});
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!s_out_valid && lat < 100) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("sweep%0d_latency", g), 64'(lat), 64'(SN));
        @(posedge clk); #1;
      end
      sweep_done++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    bit quiet;
    rst_n = 1'b0; srst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; srst_n = 1'b1;
    @(negedge clk);
    check("reset_state", 64'({in_ready, out_valid, cout, overflow, sum}), 64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
    @(posedge clk); #1;

    run_op(16'd23,    16'd6,     1'b0, 1'b0, {1'b0, 1'b0, 16'h001D}, 1'b1);
    run_op(16'hFFFF,  16'hFFFF,  1'b0, 1'b0, {1'b0, 1'b1, 16'hFFFE}, 1'b1);
    run_op(16'hFFFF,  16'h0000,  1'b1, 1'b0, {1'b0, 1'b1, 16'h0000}, 1'b1);
    run_op(16'h7FFF,  16'h0001,  1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}, 1'b0);
    run_op(16'h8000,  16'h8000,  1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}, 1'b0);
    run_op(16'h8000,  16'hFFFF,  1'b0, 1'b0, {1'b1, 1'b1, 16'h7FFF}, 1'b0);
    run_op(16'h1234,  16'h4321,  1'b1, 1'b0, {1'b0, 1'b0, 16'h5556}, 1'b0);

    // Backpressure: result held while out_ready is low, inputs ignored
    out_ready = 1'b0;
    run_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000}, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = (k % 2) == 0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      check("backpressure_hold", 64'({out_valid, in_ready, cout, overflow, sum}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h1000}));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("release_in_ready", 64'({in_ready, out_valid}), 64'(2'b10));
    @(posedge clk); #1;

    // Reset during slice 2 of 6+6 discards the partial result
    a = 16'd6; b = 16'd6; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_mid_op", 64'({in_ready, out_valid, cout, overflow, sum}), 64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    check("no_out_after_reset", 64'(quiet), 64'(1));
    @(posedge clk); #1;
    run_op(16'd6, 16'd6, 1'b0, 1'b0, {1'b0, 1'b0, 16'h000C}, 1'b1);

`ifdef RCA_SEQ_SUB_EN
    run_op(16'd6, 16'd23, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFEF}, 1'b1);
`endif

    t = 0;
    while (sweep_done < 3 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check("sweeps_complete", 64'(sweep_done), 64'(3));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
